// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: conditions the raw lines, deframes 11-bit frames and
// resolves E0/F0 prefixes into one-cycle key events with a three-event history.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_break,
  output logic        frame_err,
  output logic [29:0] scancode
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Good frame: odd parity over data+parity bit and stop bit high.
  function automatic logic frame_ok(input logic [9:0] frm);
    return (^frm[8:0]) & frm[9];
  endfunction

  logic          clk_meta_r, clk_sync_r, clk_filt_r, clk_filt_d_r;
  logic          data_meta_r, data_sync_r, data_filt_r;
  logic [FW-1:0] clk_cnt_r, data_cnt_r;
  logic          fall_s;

  state_t        state_r;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic [TW-1:0] to_cnt_r;
  logic          ext_pend_r, brk_pend_r;
  logic          key_valid_r, frame_err_r, key_ext_r, key_break_r;
  logic [7:0]    key_code_r;
  logic [29:0]   scancode_r;

  assign fall_s = clk_filt_d_r & ~clk_filt_r;

  // Synchronize both lines and require FILTER_LEN cycles of a new level before accepting it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_meta_r   <= 1'b1;
      clk_sync_r   <= 1'b1;
      clk_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
      data_meta_r  <= 1'b1;
      data_sync_r  <= 1'b1;
      data_filt_r  <= 1'b1;
      clk_cnt_r    <= '0;
      data_cnt_r   <= '0;
    end else begin
      clk_meta_r   <= ps2_clk;
      clk_sync_r   <= clk_meta_r;
      data_meta_r  <= ps2_data;
      data_sync_r  <= data_meta_r;
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r == clk_filt_r) begin
        clk_cnt_r <= '0;
      end else if (clk_cnt_r == FILT_LAST) begin
        clk_cnt_r  <= '0;
        clk_filt_r <= clk_sync_r;
      end else begin
        clk_cnt_r <= clk_cnt_r + FW'(1);
      end
      if (data_sync_r == data_filt_r) begin
        data_cnt_r <= '0;
      end else if (data_cnt_r == FILT_LAST) begin
        data_cnt_r  <= '0;
        data_filt_r <= data_sync_r;
      end else begin
        data_cnt_r <= data_cnt_r + FW'(1);
      end
    end
  end

  // Frame FSM, prefix tracking and registered event outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 10'd0;
      to_cnt_r    <= '0;
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      key_ext_r   <= 1'b0;
      key_break_r <= 1'b0;
      key_code_r  <= 8'd0;
      scancode_r  <= 30'd0;
    end else begin
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          to_cnt_r <= '0;
          if (fall_s) begin
            if (!data_filt_r) begin
              state_r   <= DATA;
              bit_cnt_r <= 4'd1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end
        end
        DATA: begin
          if (fall_s) begin
            to_cnt_r  <= '0;
            shift_r   <= {data_filt_r, shift_r[9:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd10) begin
              state_r <= CHECK;
            end
          end else if (to_cnt_r == TO_LAST) begin
            to_cnt_r    <= '0;
            bit_cnt_r   <= 4'd0;
            frame_err_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
          end
        end
        CHECK: begin
          state_r   <= IDLE;
          bit_cnt_r <= 4'd0;
          if (!frame_ok(shift_r)) begin
            frame_err_r <= 1'b1;
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
          end else if (shift_r[7:0] == 8'hE0) begin
            ext_pend_r <= 1'b1;
          end else if (shift_r[7:0] == 8'hF0) begin
            brk_pend_r <= 1'b1;
          end else begin
            key_valid_r <= 1'b1;
            key_code_r  <= shift_r[7:0];
            key_ext_r   <= ext_pend_r;
            key_break_r <= brk_pend_r;
            scancode_r  <= {scancode_r[19:0], brk_pend_r, ext_pend_r, shift_r[7:0]};
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign key_valid = key_valid_r;
  assign frame_err = frame_err_r;
  assign key_code  = key_code_r;
  assign key_ext   = key_ext_r;
  assign key_break = key_break_r;
  assign scancode  = scancode_r;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: a byte-level model queues expected events,
// a negedge monitor pops and compares them whenever the DUT strobes.
module tb_ps2_scancode_rx;

  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 2000;
  localparam int          HALF           = 40;

  logic        clock = 1'b0;
  logic        reset, ps2_clk, ps2_data;
  logic        key_valid, key_ext, key_break, frame_err;
  logic [7:0]  key_code;
  logic [29:0] scancode;

  typedef struct {
    logic        err;
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic [29:0] sc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_ev;
  int          checks   = 0;
  int          failures = 0;
  logic        m_ext    = 1'b0;
  logic        m_brk    = 1'b0;
  logic [29:0] m_sc     = 30'd0;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .frame_err(frame_err), .scancode(scancode)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.code = 8'd0; e.ext = 1'b0; e.brk = 1'b0; e.sc = 30'd0;
    exp_q.push_back(e);
  endtask

  // Byte-level reference model of prefix resolution and history.
  task automatic expect_byte(input logic [7:0] b, input bit bad);
    ev_t e;
    if (bad) begin
      push_err();
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m_sc  = {m_sc[19:0], m_brk, m_ext, b};
      e.err = 1'b0; e.code = b; e.ext = m_ext; e.brk = m_brk; e.sc = m_sc;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par);
    logic [10:0] frm;
    expect_byte(b, flip_par);
    frm = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(frm[i]);
    wait_clk(HALF);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, frame_err}, 32'd0);
    chk({tag, "_code"},  {24'd0, key_code},  32'd0);
    chk({tag, "_flags"}, {30'd0, key_break, key_ext}, 32'd0);
    chk({tag, "_sc"},    {2'd0, scancode},   32'd0);
  endtask

  // Scoreboard monitor: every strobe cycle consumes exactly one expected event.
  always @(negedge clock) begin
    if (reset === 1'b1 && (key_valid === 1'b1 || frame_err === 1'b1)) begin
      chk("strobe_excl", {31'd0, key_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, frame_err, key_valid}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("is_err", {31'd0, frame_err}, {31'd0, mon_ev.err});
        if (!mon_ev.err) begin
          chk("key_code",  {24'd0, key_code},  {24'd0, mon_ev.code});
          chk("key_ext",   {31'd0, key_ext},   {31'd0, mon_ev.ext});
          chk("key_break", {31'd0, key_break}, {31'd0, mon_ev.brk});
          chk("scancode",  {2'd0, scancode},   {2'd0, mon_ev.sc});
        end
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    chk_zero_outputs("reset");
    reset = 1'b1;
    wait_clk(20);

    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("brk_hist", {12'd0, scancode[19:0]}, {12'd0, 10'h01C, 10'h21C});

    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("arrow_hist", {12'd0, scancode[19:0]}, {12'd0, 10'h175, 10'h375});

    send_frame(8'hE0, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);

    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0);

    // Partial frame (start + 4 data bits) then silence on ps2_clk.
    push_err();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    ps2_data = 1'b1;
    wait_clk(TIMEOUT_CYCLES + 200);
    send_frame(8'h23, 1'b0);

    // Reset after six bits of a frame in flight.
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    ps2_data = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_zero_outputs("midreset");
    @(negedge clock);
    reset = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_sc  = 30'd0;
    wait_clk(20);
    send_frame(8'h3C, 1'b0);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_clk(1);
    chk("queue_drained", exp_q.size(), 32'd0);
    wait_clk(100);
    chk("hold_code", {24'd0, key_code}, {24'd0, 8'h3C});
    chk("hold_sc", {2'd0, scancode}, {2'd0, 20'd0, 10'h03C});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives the PS/2 keyboard serial stream (device-to-host direction) and turns it into decoded key events for the game-control FSM. It resolves the 0xE0 (extended) and 0xF0 (break) prefixes. Each completed key event is presented as a one-cycle strobe. It also keeps a three-event history on the 30-bit `scancode` bus that the FSM consumes.

## Interface
Parameters:
- `FILTER_LEN`, 8: system-clock cycles a synchronized PS/2 line must hold a new level before the filtered value changes.
- `TIMEOUT_CYCLES`, 200000: idle cycles allowed between falling edges inside a frame (2 ms at 100 MHz).

Ports:
- `clock`  in  1  system clock; the only clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous.
- `key_valid`  out  1  one-cycle strobe when a complete key event is decoded.
- `key_code`  out  8  final (non-prefix) byte of the event.
- `key_ext`  out  1  an 0xE0 prefix preceded this event.
- `key_break`  out  1  an 0xF0 prefix preceded this event (key release).
- `frame_err`  out  1  one-cycle strobe on a bad start, parity or stop bit, or on a timeout.
- `scancode`  out  30  event history: {ev2, ev1, ev0}, each `{key_break, key_ext, key_code}`; ev0 is in [9:0] and is the newest.

## Operation
- Input conditioning:
  - Two-flop synchronizer on each PS/2 line, then a saturating filter counter per line, `FILTER_LEN` deep.
  - The filtered lines reset to 1.
  - A falling edge is a filtered `ps2_clk` 1→0 transition, detected as a one-cycle `fall` pulse.
- Frame format: 11 bits sampled on `fall`. Start bit = 0, then 8 data bits LSB first, then odd parity, then stop bit = 1.
- State machine:
  - IDLE: on `fall` with data=0, go to DATA with bit count = 1. On `fall` with data=1 (bad start), pulse `frame_err` and stay in IDLE.
  - DATA: shift one bit on each `fall` and increment the 4-bit count. When the 11th bit (the stop bit) is captured, go to CHECK.
  - DATA: if `TIMEOUT_CYCLES` consecutive cycles pass with no `fall`, discard the partial frame, pulse `frame_err` and go to IDLE. The timeout counter clears on every `fall`.
  - CHECK (one cycle): evaluate the frame and return to IDLE.
    - The frame is good when parity XOR data = 1 and stop = 1.
    - A bad frame pulses `frame_err`, discards the byte and clears both pending prefixes.
- Byte decode (good frames only):
  - 0xE0: set `ext_pend`; no strobe.
  - 0xF0: set `brk_pend`; no strobe.
  - Any other byte:
    - pulse `key_valid`;
    - load `key_code`, `key_ext` = `ext_pend`, `key_break` = `brk_pend`;
    - clear both pending flags;
    - `scancode` ← {scancode[19:0], brk, ext, byte}.
  - Repeated prefixes are idempotent: E0 E0 75 yields a single extended event.
- `key_code`, `key_ext`, `key_break` and `scancode` hold their values until the next event.
- Reset (`reset`=0 at a clock edge):
  - state goes to IDLE; bit count, timeout counter, pending flags and filters clear;
  - all outputs go to 0, except the filtered lines, which go to 1.
  - A frame in progress is abandoned. Bits arriving after reset releases are accepted only from a valid start bit.

## Timing
- Sampling: data is sampled from the filtered `ps2_data` in the same cycle that `fall` is asserted.
- Edge latency: raw line edge to `fall` is 2 synchronizer cycles + `FILTER_LEN` + 1 cycles.
- Decode latency: `fall` of the stop bit at cycle N → CHECK at N+1 → `key_valid`/`frame_err` high during N+2. The data outputs become valid at N+2, coincident with the strobe.
- Strobes are exactly one cycle wide. `key_valid` and `frame_err` are never high in the same cycle.
- Event spacing: at least 11 PS/2 clocks separate strobes, so there is no back-pressure and no buffering.
- Timeout `frame_err` is asserted in the cycle after the counter reaches `TIMEOUT_CYCLES`-1.
- Reset dominates everything: if reset is asserted in the cycle a strobe would occur, the strobe is suppressed.

## Test plan
- Make 0x1C ('A'), with odd parity set correctly → one `key_valid` pulse, `key_code`=0x1C, `key_ext`=0, `key_break`=0, `scancode`[9:0]=0x01C.
- Sequence 1C, F0 1C → two strobes. After the second: `key_break`=1, `scancode`[9:0]=0x21C, `scancode`[19:10]=0x01C.
- Sequence E0 75 then E0 F0 75 (up-arrow press and release) → exactly two strobes. `scancode`[19:0]={0x175, 0x375}, and no strobe on any prefix byte.
- Frame F0 with its parity bit flipped, then 1C → `frame_err` pulse with no `key_valid`. The next event has `key_break`=0 and code 0x1C.
- Send 5 bits and then stop toggling `ps2_clk` → `frame_err` after `TIMEOUT_CYCLES` cycles. A following full 0x23 frame decodes normally, with `key_code`=0x23.
- Drive `reset`=0 for one cycle after bit 6 of a frame, then send 0x3C → all outputs 0 during reset, the partial frame yields no strobe, and 0x3C decodes cleanly.
